if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//  Instruction-fetch producer for the IF/ID pipeline register.
//  - Owns the PC and issues word fetches to the memory controller.
//  - Presents {if_pc, if_inst} plus a valid flag, and raises if_stall_req while no instruction is ready.
//  - Redirects on ex_flag (taken branch/jump) and discards any in-flight fetch.
// PARAMETERS
//  RESET_PC      32'h0000_0000  PC loaded on reset
//  ICACHE_LINES  64             direct-mapped I-cache entries; power of 2, >=2; used only with ICACHE_EN
// PORTS
//  clk            in   1   clock, all state on posedge
//  rst_n          in   1   asynchronous, active-low reset
//  stall_if       in   1   downstream hold; instruction not consumed this cycle
//  ex_flag        in   1   redirect request from EX (1-cycle pulse)
//  ex_target_pc   in   32  redirect target, valid with ex_flag
//  mem_req        out  1   fetch request to memory controller
//  mem_addr       out  32  word-aligned fetch address
//  mem_ready      in   1   1-cycle pulse: mem_data valid, request complete
//  mem_data       in   32  fetched instruction word
//  if_valid       out  1   {if_pc, if_inst} hold a valid instruction
//  if_pc          out  32  PC of presented instruction
//  if_inst        out  32  presented instruction
//  if_stall_req   out  1   = ~if_valid (combinational); asks stall controller to hold IF
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, state=IDLE; mem_req=0, mem_addr=0, if_valid=0, if_pc=0, if_inst=0. Cache valid bits cleared.
//  FSM states: IDLE, WAIT, HOLD, FLUSH.
//  IDLE:  mem_req<=1, mem_addr<=pc; ->WAIT (cache hit path: see CONFIGURATION).
//  WAIT:  mem_req/mem_addr held stable until mem_ready. Never withdrawn except by reset.
//         On mem_ready: if_inst<=mem_data, if_pc<=pc, if_valid<=1, pc<=pc+4, mem_req<=0; ->HOLD.
//  HOLD:  Instruction is consumed on a cycle with if_valid=1 and stall_if=0 and ex_flag=0.
//         On consume, if_valid<=0; ->IDLE. Otherwise outputs are held unchanged.
//  FLUSH: A stale request is outstanding. mem_req stays high until mem_ready.
//         On mem_ready the data is dropped, mem_req<=0; ->IDLE.
//  ex_flag has priority over everything except reset, in every state:
//         pc<=ex_target_pc, if_valid<=0.
//         Next state: FLUSH if WAIT && !mem_ready; otherwise IDLE.
//         If WAIT && mem_ready coincide with ex_flag, the returned data is dropped and not cached.
//  Latency (miss): ex_flag or consume at cycle t -> mem_req at t+1 -> if_valid the cycle after mem_ready.
//  PC arithmetic is mod 2^32; 32'hFFFF_FFFC+4 wraps to 0.
//  ex_target_pc[1:0] is ignored; the PC is forced word-aligned.
//  stall_if while if_valid=0 has no effect on fetching.
// CONFIGURATION
//  ICACHE_EN defined:
//  - Direct-mapped, one word per line.
//  - Index = pc[IDX+1:2], with IDX=log2(ICACHE_LINES); tag = pc[31:IDX+2]; valid bit per line.
//  - IDLE hit: no mem_req. if_inst<=line data, if_pc<=pc, if_valid<=1, pc<=pc+4; ->HOLD (1 cycle).
//  - Fill on each non-dropped mem_ready. FLUSH responses are never written.
//  ICACHE_EN undefined:
//  - No cache storage; every fetch goes through IDLE->WAIT.
// TESTING
//  1. Reset then mem_ready 3 cycles after each mem_req, stall_if=0:
//     mem_addr sequence 0,4,8; if_pc/if_inst match, if_stall_req high between instructions.
//  2. if_valid=1, stall_if=1 for 5 cycles: if_pc/if_inst unchanged, no new mem_req.
//     stall_if=0 -> next fetch at pc+4.
//  3. ex_flag with target 32'h100 while WAIT on addr 8, mem_ready 2 cycles later with 32'hDEAD_BEEF:
//     data dropped, next mem_addr=32'h100, if_valid never shows BEEF.
//  4. ex_flag in the same cycle as mem_ready: data dropped, FSM->IDLE, next mem_addr=ex_target_pc.
//  5. PC wrap: reset with RESET_PC=32'hFFFF_FFF8, two fetches -> mem_addr FFFF_FFF8, FFFF_FFFC, 0000_0000.
//  6. ICACHE_EN: loop 0->8 via ex_flag twice. Second pass: no mem_req; each if_valid 1 cycle after IDLE.
//     Reset mid-loop -> misses again.

Source files
------------

// File: rtl/if_fetch_if.sv
// Memory-controller fetch bus between if_fetch (master) and the instruction memory (slave).
//   mem_req    master->slave  fetch request, held until mem_ready
//   mem_addr   master->slave  word-aligned fetch address
//   mem_ready  slave->master  1-cycle completion pulse, mem_data valid
//   mem_data   slave->master  fetched instruction word
interface if_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_data;

  modport master (output mem_req, output mem_addr, input mem_ready, input mem_data);
  modport slave  (input mem_req, input mem_addr, output mem_ready, output mem_data);
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch producer feeding the IF/ID pipeline register.
// Owns the PC, fetches one word at a time over the mem bus and presents
// {if_pc, if_inst} with if_valid. ex_flag redirects and drops any in-flight fetch.
// Optional direct-mapped I-cache (one word per line) enabled by defining ICACHE_EN.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   stall_if          downstream hold, presented instruction not consumed
//   ex_flag           redirect pulse from EX, target in ex_target_pc
//   mem               fetch bus (master side)
//   if_valid/pc/inst  presented instruction (registered)
//   if_stall_req      combinational ~if_valid
module if_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned ICACHE_LINES = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_if,
  input  logic             ex_flag,
  input  logic [31:0]      ex_target_pc,
  if_fetch_if.master       mem,
  output logic             if_valid,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_inst,
  output logic             if_stall_req
);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, FLUSH} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        mem_req_q;
  logic [31:0] mem_addr_q;
  logic        if_valid_q;
  logic [31:0] if_pc_q;
  logic [31:0] if_inst_q;
  logic [31:0] pc_inc_c;
  logic [31:0] redirect_pc_c;
  logic        fill_c;
  logic        hit_c;
  logic [31:0] hit_data_c;

  // Low target bits are discarded; the PC is always word aligned.
  logic [1:0]  unused_tgt_lsb;
  assign unused_tgt_lsb = ex_target_pc[1:0];
  assign redirect_pc_c  = {ex_target_pc[31:2], 2'b00};
  assign pc_inc_c       = pc_q + 32'd4;

  // A response is kept only when it completes a live fetch that is not being redirected.
  assign fill_c = (state_q == WAIT) && mem.mem_ready && !ex_flag;

`ifdef ICACHE_EN
  localparam int unsigned IDX   = $clog2(ICACHE_LINES);
  localparam int unsigned TAG_W = 30 - IDX;

  logic [31:0]       line_data_q [ICACHE_LINES];
  logic [TAG_W-1:0]  line_tag_q  [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] line_vld_q;
  logic [IDX-1:0]    idx_c;
  logic [TAG_W-1:0]  tag_c;

  assign idx_c      = pc_q[IDX+1:2];
  assign tag_c      = pc_q[31:IDX+2];
  assign hit_c      = line_vld_q[idx_c] && (line_tag_q[idx_c] == tag_c);
  assign hit_data_c = line_data_q[idx_c];

  // Line storage needs no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (fill_c) begin
      line_data_q[idx_c] <= mem.mem_data;
      line_tag_q[idx_c]  <= tag_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      line_vld_q <= '0;
    else if (fill_c) line_vld_q[idx_c] <= 1'b1;
  end
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = 32'(ICACHE_LINES);
  assign hit_c      = 1'b0;
  assign hit_data_c = 32'd0;
`endif

  // Fetch FSM; ex_flag outranks every state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'd0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'd0;
      if_inst_q  <= 32'd0;
    end else if (ex_flag) begin
      pc_q       <= redirect_pc_c;
      if_valid_q <= 1'b0;
      // An outstanding request cannot be withdrawn, so drain it in FLUSH.
      if ((state_q == WAIT || state_q == FLUSH) && !mem.mem_ready) begin
        state_q <= FLUSH;
      end else begin
        state_q   <= IDLE;
        mem_req_q <= 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hit_c) begin
            if_inst_q  <= hit_data_c;
            if_pc_q    <= pc_q;
            if_valid_q <= 1'b1;
            pc_q       <= pc_inc_c;
            state_q    <= HOLD;
          end else begin
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_q;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (mem.mem_ready) begin
            if_inst_q  <= mem.mem_data;
            if_pc_q    <= pc_q;
            if_valid_q <= 1'b1;
            pc_q       <= pc_inc_c;
            mem_req_q  <= 1'b0;
            state_q    <= HOLD;
          end
        end
        HOLD: begin
          if (!stall_if) begin
            if_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        FLUSH: begin
          if (mem.mem_ready) begin
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = mem_addr_q;
  assign if_valid     = if_valid_q;
  assign if_pc        = if_pc_q;
  assign if_inst      = if_inst_q;
  assign if_stall_req = ~if_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: table-driven fetch sequence plus hand-written
// redirect, wrap and (with ICACHE_EN) cache-hit sequences.
module tb_if_fetch;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_if;
  logic        ex_flag;
  logic [31:0] ex_target_pc;

  logic        m_valid, m_stall;
  logic [31:0] m_pc, m_inst;
  logic        w_valid, w_stall;
  logic [31:0] w_pc, w_inst;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch_if mif ();
  if_fetch_if wif ();

  if_fetch u_dut (
    .clk(clk), .rst_n(rst_n), .stall_if(stall_if), .ex_flag(ex_flag),
    .ex_target_pc(ex_target_pc), .mem(mif),
    .if_valid(m_valid), .if_pc(m_pc), .if_inst(m_inst), .if_stall_req(m_stall)
  );

  if_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst_n(rst_n), .stall_if(stall_if), .ex_flag(ex_flag),
    .ex_target_pc(ex_target_pc), .mem(wif),
    .if_valid(w_valid), .if_pc(w_pc), .if_inst(w_inst), .if_stall_req(w_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned stall;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic g_req(input bit w);
    return w ? wif.mem_req : mif.mem_req;
  endfunction
  function automatic logic [31:0] g_addr(input bit w);
    return w ? wif.mem_addr : mif.mem_addr;
  endfunction
  function automatic logic g_valid(input bit w);
    return w ? w_valid : m_valid;
  endfunction
  function automatic logic g_stall(input bit w);
    return w ? w_stall : m_stall;
  endfunction
  function automatic logic [31:0] g_pc(input bit w);
    return w ? w_pc : m_pc;
  endfunction
  function automatic logic [31:0] g_inst(input bit w);
    return w ? w_inst : m_inst;
  endfunction

  task automatic set_rdy(input bit w, input logic r, input logic [31:0] d);
    if (w) begin
      wif.mem_ready = r;
      wif.mem_data  = d;
    end else begin
      mif.mem_ready = r;
      mif.mem_data  = d;
    end
  endtask

  // Bounded wait for a fetch request; a timeout is recorded as a failure.
  task automatic wait_req(input bit w);
    for (int i = 0; i < 10; i++) begin
      if (g_req(w)) break;
      tick();
    end
    chk("req_seen", 32'(g_req(w)), 32'd1);
  endtask

  // One full miss fetch: request, 3-cycle memory latency, optional stall, consume.
  task automatic do_fetch(input bit w, input logic [31:0] addr, input logic [31:0] data,
                          input int unsigned stall);
    wait_req(w);
    chk("req_addr", g_addr(w), addr);
    chk("stall_req_wait", 32'(g_stall(w)), 32'd1);
    chk("valid_wait", 32'(g_valid(w)), 32'd0);
    repeat (3) tick();
    chk("req_held", 32'(g_req(w)), 32'd1);
    chk("addr_held", g_addr(w), addr);
    set_rdy(w, 1'b1, data);
    tick();
    set_rdy(w, 1'b0, 32'd0);
    chk("valid", 32'(g_valid(w)), 32'd1);
    chk("if_pc", g_pc(w), addr);
    chk("if_inst", g_inst(w), data);
    chk("stall_req_hold", 32'(g_stall(w)), 32'd0);
    chk("req_drop", 32'(g_req(w)), 32'd0);
    for (int s = 0; s < int'(stall); s++) begin
      stall_if = 1'b1;
      tick();
      chk("stall_valid", 32'(g_valid(w)), 32'd1);
      chk("stall_pc", g_pc(w), addr);
      chk("stall_inst", g_inst(w), data);
      chk("stall_no_req", 32'(g_req(w)), 32'd0);
    end
    stall_if = 1'b0;
    tick();
    chk("consumed", 32'(g_valid(w)), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall_if = 1'b0;
    ex_flag = 1'b0;
    ex_target_pc = 32'd0;
    set_rdy(1'b0, 1'b0, 32'd0);
    set_rdy(1'b1, 1'b0, 32'd0);
    repeat (2) tick();
    chk("rst_req", 32'(mif.mem_req), 32'd0);
    chk("rst_addr", mif.mem_addr, 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_pc", m_pc, 32'd0);
    chk("rst_inst", m_inst, 32'd0);
    chk("rst_stall_req", 32'(m_stall), 32'd1);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{addr: 32'h0000_0000, data: 32'h0000_0013, stall: 0};
    vecs[1] = '{addr: 32'h0000_0004, data: 32'h1234_5678, stall: 0};
    vecs[2] = '{addr: 32'h0000_0008, data: 32'hCAFE_F00D, stall: 0};
    vecs[3] = '{addr: 32'h0000_000C, data: 32'hA5A5_5A5A, stall: 5};
    vecs[4] = '{addr: 32'h0000_0010, data: 32'h0BAD_C0DE, stall: 0};

    do_reset();

    // Sequential fetches, including a 5-cycle downstream stall.
    for (int i = 0; i < 5; i++) begin
      do_fetch(1'b0, vecs[i].addr, vecs[i].data, vecs[i].stall);
    end

    // Redirect while waiting: stale request drains, its data is dropped.
    wait_req(1'b0);
    chk("t3_addr", mif.mem_addr, 32'h0000_0014);
    tick();
    ex_flag = 1'b1;
    ex_target_pc = 32'h0000_0100;
    tick();
    ex_flag = 1'b0;
    chk("t3_flush_req", 32'(mif.mem_req), 32'd1);
    chk("t3_flush_addr", mif.mem_addr, 32'h0000_0014);
    tick();
    set_rdy(1'b0, 1'b1, 32'hDEAD_BEEF);
    tick();
    set_rdy(1'b0, 1'b0, 32'd0);
    chk("t3_drop_req", 32'(mif.mem_req), 32'd0);
    chk("t3_drop_valid", 32'(m_valid), 32'd0);
    do_fetch(1'b0, 32'h0000_0100, 32'h1111_1111, 0);

    // Redirect coinciding with mem_ready; unaligned target is word-aligned.
    wait_req(1'b0);
    chk("t4_addr", mif.mem_addr, 32'h0000_0104);
    tick();
    ex_flag = 1'b1;
    ex_target_pc = 32'h0000_0203;
    set_rdy(1'b0, 1'b1, 32'h0000_0BAD);
    tick();
    ex_flag = 1'b0;
    set_rdy(1'b0, 1'b0, 32'd0);
    chk("t4_valid", 32'(m_valid), 32'd0);
    chk("t4_req", 32'(mif.mem_req), 32'd0);
    do_fetch(1'b0, 32'h0000_0200, 32'h2222_2222, 0);

    // Redirect while holding a stalled instruction.
    wait_req(1'b0);
    chk("t5_addr", mif.mem_addr, 32'h0000_0204);
    set_rdy(1'b0, 1'b1, 32'h3333_3333);
    tick();
    set_rdy(1'b0, 1'b0, 32'd0);
    chk("t5_valid", 32'(m_valid), 32'd1);
    stall_if = 1'b1;
    tick();
    ex_flag = 1'b1;
    ex_target_pc = 32'h0000_0300;
    tick();
    ex_flag = 1'b0;
    stall_if = 1'b0;
    chk("t5_redirect_valid", 32'(m_valid), 32'd0);
    do_fetch(1'b0, 32'h0000_0300, 32'h4444_4444, 0);

    // PC wrap on the second instance.
    do_reset();
    do_fetch(1'b1, 32'hFFFF_FFF8, 32'h5555_0001, 0);
    do_fetch(1'b1, 32'hFFFF_FFFC, 32'h5555_0002, 0);
    do_fetch(1'b1, 32'h0000_0000, 32'h5555_0003, 0);

`ifdef ICACHE_EN
    // Second pass over 0..8 hits in the cache; a reset forces misses again.
    do_reset();
    for (int i = 0; i < 3; i++) do_fetch(1'b0, vecs[i].addr, vecs[i].data, 0);
    wait_req(1'b0);
    ex_flag = 1'b1;
    ex_target_pc = 32'h0000_0000;
    tick();
    ex_flag = 1'b0;
    set_rdy(1'b0, 1'b1, 32'h7777_7777);
    tick();
    set_rdy(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hit_valid", 32'(m_valid), 32'd1);
      chk("hit_pc", m_pc, vecs[i].addr);
      chk("hit_inst", m_inst, vecs[i].data);
      chk("hit_no_req", 32'(mif.mem_req), 32'd0);
      tick();
    end
    do_reset();
    do_fetch(1'b0, 32'h0000_0000, 32'h0000_0013, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
